read_return_sequencer: RTL and testbench
========================================

// Module: read_return_sequencer
// PURPOSE
//  Returns read data from the four backend (bank) controllers to the single frontend read-data channel, in request order.
//  The frontend dispatcher pushes the target bank ID of every read it issues into an in-order tag FIFO.
//  The sequencer pops the backend whose bank ID is at the FIFO head, and only that backend, via o_backend_controller_ren_bcN.
//  It registers the popped word onto o_read_data. It sits between the backend controllers and the global controller output port.
// PARAMETERS
//  DATA_W          `GLOBAL_CONTROLLER_WORD_SIZE  width of one read data word
//  DEPTH           16     tag FIFO entries; power of 2, >= 2
//  TIMEOUT_CYCLES  1024   head-wait limit, used only with RD_RETURN_TIMEOUT_EN
// PORTS
//  i_clk                        in   1          clock, all logic on rising edge
//  i_rst_n                      in   1          asynchronous active-low reset
//  i_issue_valid                in   1          a read to bank i_issue_bank was issued this cycle
//  i_issue_bank                 in   2          bank ID (0..3) of that read
//  o_order_full                 out  1          tag FIFO holds DEPTH entries
//  o_order_count                out  $clog2(DEPTH)+1  number of outstanding reads
//  i_returned_data_valid_bc0..3 in   1 each     backend N output FIFO is non-empty (first-word-fall-through)
//  i_returned_data_bc0..3       in   DATA_W each  head word of backend N output FIFO
//  o_backend_controller_ren_bc0..3 out 1 each   pop strobe to backend N
//  o_read_data_valid            out  1          one-cycle pulse: o_read_data is valid
//  o_read_data                  out  DATA_W     returned read word
//  o_overflow_err               out  1          sticky: push dropped while full
//  o_timeout_err                out  1          sticky: head wait exceeded limit (macro only)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO pointers and count 0; o_read_data 0; error flags 0.
//  Tag FIFO: circular, pointers of $clog2(DEPTH) bits that wrap at DEPTH; o_order_count holds the occupancy.
//   - push when i_issue_valid && (!full || pop this cycle); push and pop in the same cycle leave the count unchanged.
//   - push while full with no pop: dropped; o_overflow_err set and held until reset.
//  Pop/select (combinational): head = FIFO[rd_ptr]; pop = !empty && i_returned_data_valid_bc[head].
//   - o_backend_controller_ren_bc[head] = pop; every other ren is 0. At most one ren is high per cycle.
//   - valid on a non-head bank is ignored; that data stays in its backend.
//   - valid while the FIFO is empty: no ren, no output.
//  Output register: on the pop edge, o_read_data <= i_returned_data_bc[head] and o_read_data_valid <= 1.
//   - o_read_data_valid is 0 in any cycle without a pop. o_read_data holds its last value when not valid.
//   - latency is 1 cycle from ren to o_read_data_valid. Throughput is 1 word/cycle. There is no backpressure on the read channel.
//  Pushing into an empty FIFO: the new entry becomes head on the next cycle (no push-to-pop bypass).
//  Reset asserted mid-operation: all outstanding tags are discarded immediately and no ren is asserted.
// CONFIGURATION
//  RD_RETURN_TIMEOUT_EN defined:
//   - a wait counter counts cycles with !empty && !pop; it clears on pop or when empty.
//   - o_timeout_err is set once the counter reaches TIMEOUT_CYCLES, and is sticky until reset.
//   - the counter saturates at TIMEOUT_CYCLES.
//  RD_RETURN_TIMEOUT_EN not defined: no counter is built; o_timeout_err is tied to 0.
// TESTING
//  1 In-order: push banks 2,0; bc0 valid=1 data=A0 from cycle 1, bc2 valid=1 data=C2 from cycle 3
//     -> no ren until cycle 3; ren_bc2 at cycle 3, out C2 at cycle 4; ren_bc0 at cycle 4, out A0 at cycle 5.
//  2 Back-to-back: push 0,1,2,3 with all backends valid
//     -> ren_bc0..bc3 on 4 consecutive cycles; 4 consecutive o_read_data_valid pulses in bank order.
//  3 Full: push 16 with no valid -> o_order_full=1, count=16.
//     -> a 17th push sets o_overflow_err.
//     -> a push together with a pop while full is accepted, count stays 16.
//  4 Wrap: 40 random-bank pushes/pops interleaved -> output order equals push order; count returns to 0.
//  5 Stray/reset: bc1 valid while empty -> no ren.
//     -> assert i_rst_n=0 with 5 tags queued -> count=0, all outputs 0 at once.
//  6 Timeout (macro on, TIMEOUT_CYCLES=8): push bank 3, hold bc3 valid=0 -> o_timeout_err=1 after 8 cycles.
//     -> o_timeout_err stays 1 after the word is finally returned.

Source files
------------

// File: rtl/read_return_sequencer.sv
// rtl/read_return_sequencer.sv - in-order read-data return sequencer across four bank controllers
//
// Purpose:
//   Tracks the bank ID of every issued read in an in-order tag FIFO and pops
//   only the backend controller whose bank is at the FIFO head, registering
//   the popped word onto the frontend read-data channel.
//
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_issue_valid, i_issue_bank        read issued to bank i_issue_bank (0..3)
//   o_order_full, o_order_count        tag FIFO full flag and occupancy
//   i_returned_data_valid_bc0..3       backend N output FIFO non-empty (FWFT)
//   i_returned_data_bc0..3             backend N head word
//   o_backend_controller_ren_bc0..3    pop strobe to backend N (at most one high)
//   o_read_data_valid, o_read_data     registered returned word, one-cycle valid
//   o_overflow_err                     sticky: push dropped while full
//   o_timeout_err                      sticky: head wait reached TIMEOUT_CYCLES
//
// Configuration macro:
//   RD_RETURN_TIMEOUT_EN  builds the head-wait counter; otherwise o_timeout_err is 0.

`ifndef GLOBAL_CONTROLLER_WORD_SIZE
`define GLOBAL_CONTROLLER_WORD_SIZE 32
`endif

module read_return_sequencer #(
  parameter int DATA_W         = `GLOBAL_CONTROLLER_WORD_SIZE,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_issue_valid,
  input  logic [1:0]               i_issue_bank,
  output logic                     o_order_full,
  output logic [$clog2(DEPTH):0]   o_order_count,
  input  logic                     i_returned_data_valid_bc0,
  input  logic                     i_returned_data_valid_bc1,
  input  logic                     i_returned_data_valid_bc2,
  input  logic                     i_returned_data_valid_bc3,
  input  logic [DATA_W-1:0]        i_returned_data_bc0,
  input  logic [DATA_W-1:0]        i_returned_data_bc1,
  input  logic [DATA_W-1:0]        i_returned_data_bc2,
  input  logic [DATA_W-1:0]        i_returned_data_bc3,
  output logic                     o_backend_controller_ren_bc0,
  output logic                     o_backend_controller_ren_bc1,
  output logic                     o_backend_controller_ren_bc2,
  output logic                     o_backend_controller_ren_bc3,
  output logic                     o_read_data_valid,
  output logic [DATA_W-1:0]        o_read_data,
  output logic                     o_overflow_err,
  output logic                     o_timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("read_return_sequencer: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("read_return_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0]        tag_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [1:0]        head;
  logic [3:0]        ret_valid;
  logic [3:0]        ren;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    ret_valid = {i_returned_data_valid_bc3, i_returned_data_valid_bc2,
                 i_returned_data_valid_bc1, i_returned_data_valid_bc0};
    head      = tag_mem_q[rd_ptr_q];
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    // Only the head bank may be popped; valid on any other bank is ignored.
    pop       = !empty && ret_valid[head];
    // A pop frees a slot in the same cycle, so a push while full is still accepted.
    push      = i_issue_valid && (!full || pop);

    ren = '0;
    if (pop) begin
      ren[head] = 1'b1;
    end

    case (head)
      2'd0:    head_data = i_returned_data_bc0;
      2'd1:    head_data = i_returned_data_bc1;
      2'd2:    head_data = i_returned_data_bc2;
      default: head_data = i_returned_data_bc3;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d   = overflow_q | (i_issue_valid && !push);
    read_data_d  = pop ? head_data : read_data_q;
    read_valid_d = pop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q is non-zero.
  always_ff @(posedge i_clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= i_issue_bank;
    end
  end

`ifdef RD_RETURN_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    if (empty || pop) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_W'(TIMEOUT_CYCLES)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    timeout_d = timeout_q | (wait_cnt_d == WAIT_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_timeout_err = timeout_q;
`else
  assign o_timeout_err = 1'b0;
`endif

  assign o_order_full                 = full;
  assign o_order_count                = count_q;
  assign o_backend_controller_ren_bc0 = ren[0];
  assign o_backend_controller_ren_bc1 = ren[1];
  assign o_backend_controller_ren_bc2 = ren[2];
  assign o_backend_controller_ren_bc3 = ren[3];
  assign o_read_data_valid            = read_valid_q;
  assign o_read_data                  = read_data_q;
  assign o_overflow_err               = overflow_q;

endmodule

// File: tb/tb_read_return_sequencer.sv
// tb/tb_read_return_sequencer.sv - scoreboard bench for read_return_sequencer

module tb_read_return_sequencer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          issue_valid = 1'b0;
  logic [1:0]    issue_bank = 2'd0;
  logic          full;
  logic [4:0]    count;
  logic [3:0]    rv = 4'h0;
  logic [DW-1:0] rdat [4];
  logic [3:0]    ren;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          ovf;
  logic          tmo;

  always #5 clk = ~clk;

  read_return_sequencer #(
    .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_issue_valid(issue_valid),
    .i_issue_bank(issue_bank),
    .o_order_full(full),
    .o_order_count(count),
    .i_returned_data_valid_bc0(rv[0]),
    .i_returned_data_valid_bc1(rv[1]),
    .i_returned_data_valid_bc2(rv[2]),
    .i_returned_data_valid_bc3(rv[3]),
    .i_returned_data_bc0(rdat[0]),
    .i_returned_data_bc1(rdat[1]),
    .i_returned_data_bc2(rdat[2]),
    .i_returned_data_bc3(rdat[3]),
    .o_backend_controller_ren_bc0(ren[0]),
    .o_backend_controller_ren_bc1(ren[1]),
    .o_backend_controller_ren_bc2(ren[2]),
    .o_backend_controller_ren_bc3(ren[3]),
    .o_read_data_valid(out_valid),
    .o_read_data(out_data),
    .o_overflow_err(ovf),
    .o_timeout_err(tmo)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backend FIFOs, expected output words and expected pop banks, in issue order.
  logic [DW-1:0] bq [4][$];
  logic [DW-1:0] exp_data_q [$];
  logic [1:0]    exp_ren_q [$];
  logic [3:0]    en = 4'h0;
  logic [3:0]    ren_seen = 4'h0;
  logic [DW-1:0] last_word = '0;
  logic [1:0]    eb;
  int            word_id = 0;
  bit            tmo_exp;

  // Monitor: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ren_seen = ren;
    if (ren != 4'h0) begin
      check_eq("ren_onehot", 64'($countones(ren) <= 1), 64'd1);
      if (exp_ren_q.size() == 0) begin
        check_eq("ren_unexpected", ren, 4'h0);
      end else begin
        eb = exp_ren_q.pop_front();
        check_eq("ren_bank", ren, 4'b0001 << eb);
      end
    end
    if (out_valid) begin
      if (exp_data_q.size() == 0) begin
        check_eq("data_unexpected", out_valid, 1'b0);
      end else begin
        last_word = exp_data_q.pop_front();
        check_eq("read_data", out_data, last_word);
      end
    end
  end

  // Backend model: first-word-fall-through FIFOs popped by the ren seen last cycle.
  always begin
    @(posedge clk);
    #2;
    for (int n = 0; n < 4; n++) begin
      if (ren_seen[n] && bq[n].size() > 0) void'(bq[n].pop_front());
      rv[n]   = en[n] && (bq[n].size() > 0);
      rdat[n] = (bq[n].size() > 0) ? bq[n][0] : '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] b, input bit acc);
    logic [DW-1:0] w;
    issue_valid = 1'b1;
    issue_bank  = b;
    if (acc) begin
      word_id++;
      w = {b, 30'(word_id)};
      bq[b].push_back(w);
      exp_data_q.push_back(w);
      exp_ren_q.push_back(b);
    end
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n  = 0;
    en = 4'hF;
    while (exp_data_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    check_eq(tag, exp_data_q.size(), 0);
  endtask

  task automatic measure(input int ncyc, output int pulses, output int span);
    int first;
    int last;
    first  = -1;
    last   = -1;
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (out_valid) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    span = last - first;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p;
    int s;
    for (int n = 0; n < 4; n++) rdat[n] = '0;
`ifdef RD_RETURN_TIMEOUT_EN
    tmo_exp = 1'b1;
`else
    tmo_exp = 1'b0;
`endif

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_count", count, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_ren", ren, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_tmo", tmo, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: in-order return, bank 0 ready early but must wait behind bank 2
    en = 4'b0001;
    issue(2'd2, 1'b1);
    issue(2'd0, 1'b1);
    repeat (3) begin
      tick();
      check_eq("t1_no_out", out_valid, 0);
    end
    check_eq("t1_count", count, 2);
    en = 4'b0101;
    measure(6, p, s);
    check_eq("t1_pulses", p, 2);
    check_eq("t1_span", s, 1);
    check_eq("t1_count_end", count, 0);

    // 2: back-to-back returns at one word per cycle
    en = 4'h0;
    for (int b = 0; b < 4; b++) issue(2'(b), 1'b1);
    en = 4'hF;
    measure(8, p, s);
    check_eq("t2_pulses", p, 4);
    check_eq("t2_span", s, 3);
    check_eq("t2_hold_valid", out_valid, 0);
    check_eq("t2_hold_data", out_data, last_word);

    // 3: full, overflow, push+pop while full
    en = 4'h0;
    for (int i = 0; i < DEPTH; i++) issue(2'($urandom_range(0, 3)), 1'b1);
    check_eq("t3_full", full, 1);
    check_eq("t3_count16", count, 16);
    check_eq("t3_ovf_clear", ovf, 0);
    issue(2'($urandom_range(0, 3)), 1'b0);
    check_eq("t3_ovf_set", ovf, 1);
    check_eq("t3_count_drop", count, 16);
    en = 4'b0001 << exp_ren_q[0];
    issue(2'($urandom_range(0, 3)), 1'b1);
    en = 4'h0;
    check_eq("t3_pushpop_count", count, 16);
    check_eq("t3_ovf_sticky", ovf, 1);
    drain("t3_drain", 200);
    check_eq("t3_count_end", count, 0);
    check_eq("t3_full_end", full, 0);

    // 4: pointer wrap with random banks and random backend readiness
    for (int i = 0; i < 40; i++) begin
      if (count >= 5'(DEPTH - 1)) begin
        en = 4'hF;
        while (count > 5'd8) tick();
      end
      en = 4'($urandom_range(0, 15));
      issue(2'($urandom_range(0, 3)), 1'b1);
      en = 4'($urandom_range(0, 15));
      tick();
    end
    drain("t4_drain", 300);
    check_eq("t4_count_end", count, 0);

    // 5: stray valid while empty, then reset with tags outstanding
    en = 4'b0010;
    bq[1].push_back(32'hDEAD_BEEF);
    tick();
    tick();
    check_eq("t5_stray_ren", ren, 0);
    check_eq("t5_stray_valid", out_valid, 0);
    bq[1].delete();
    en = 4'h0;
    tick();
    issue(2'd1, 1'b1);
    issue(2'd2, 1'b1);
    issue(2'd3, 1'b1);
    issue(2'd0, 1'b1);
    issue(2'd2, 1'b1);
    check_eq("t5_count5", count, 5);
    en = 4'b1101;
    tick();
    tick();
    check_eq("t5_head_blocked", ren, 0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_count", count, 0);
    check_eq("t5_rst_full", full, 0);
    check_eq("t5_rst_ren", ren, 0);
    check_eq("t5_rst_valid", out_valid, 0);
    check_eq("t5_rst_data", out_data, 0);
    check_eq("t5_rst_ovf", ovf, 0);
    check_eq("t5_rst_tmo", tmo, 0);
    exp_data_q.delete();
    exp_ren_q.delete();
    en = 4'hF;
    tick();
    tick();
    check_eq("t5_rst_ren_hold", ren, 0);
    for (int n = 0; n < 4; n++) bq[n].delete();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t5_post_count", count, 0);

    // 6: head wait limit (sticky flag only exists with the timeout macro)
    en = 4'h0;
    issue(2'd3, 1'b1);
    repeat (TO - 1) tick();
    check_eq("t6_tmo_early", tmo, 0);
    tick();
    check_eq("t6_tmo_at_limit", tmo, tmo_exp);
    drain("t6_drain", 50);
    check_eq("t6_tmo_sticky", tmo, tmo_exp);
    check_eq("t6_count_end", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
